// File: rtl/reservation_rob_if.sv
// reservation_rob_if: bundles every non-clock/reset signal of reservation_rob.
// Handshake semantics:
//   alloc  : alloc_valid is a request; it takes effect at the edge only when
//            full=0 and halt=0 at that edge (no separate ready signal).
//   disp   : disp_valid/disp_ready transfer an entry at the rising edge when
//            both are 1; disp_valid never depends on disp_ready.
//   cdb    : cdb_valid qualifies cdb_tag/cdb_data; always accepted.
//   commit : commit_valid=1 means the head entry retires at the next edge.
interface reservation_rob_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int EXEC_WIDTH = 4
) ();
  logic                  halt;
  logic                  alloc_valid;
  logic [EXEC_WIDTH-1:0] alloc_exec_id;
  logic                  rs1_valid;
  logic [TAG_WIDTH-1:0]  rs1_tag;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic                  rs2_valid;
  logic [TAG_WIDTH-1:0]  rs2_tag;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic [TAG_WIDTH-1:0]  alloc_tag;
  logic                  full;
  logic                  cdb_valid;
  logic [TAG_WIDTH-1:0]  cdb_tag;
  logic [DATA_WIDTH-1:0] cdb_data;
  logic                  disp_valid;
  logic                  disp_ready;
  logic [DATA_WIDTH-1:0] disp_op1;
  logic [DATA_WIDTH-1:0] disp_op2;
  logic [EXEC_WIDTH-1:0] disp_exec_id;
  logic [TAG_WIDTH-1:0]  disp_tag;
  logic                  commit_valid;
  logic [TAG_WIDTH-1:0]  commit_tag;
  logic [DATA_WIDTH-1:0] commit_data;

  modport master (
    output halt, alloc_valid, alloc_exec_id,
    output rs1_valid, rs1_tag, rs1_data, rs2_valid, rs2_tag, rs2_data,
    output cdb_valid, cdb_tag, cdb_data, disp_ready,
    input  alloc_tag, full, disp_valid, disp_op1, disp_op2, disp_exec_id,
    input  disp_tag, commit_valid, commit_tag, commit_data
  );

  modport slave (
    input  halt, alloc_valid, alloc_exec_id,
    input  rs1_valid, rs1_tag, rs1_data, rs2_valid, rs2_tag, rs2_data,
    input  cdb_valid, cdb_tag, cdb_data, disp_ready,
    output alloc_tag, full, disp_valid, disp_op1, disp_op2, disp_exec_id,
    output disp_tag, commit_valid, commit_tag, commit_data
  );
endinterface

// File: rtl/reservation_rob.sv
// reservation_rob: combined reservation station / reorder buffer.
// Entries are allocated in order at the tail, wait for operands on the CDB,
// are dispatched oldest-ready-first, and retire in order from the head.
// Tag = entry index. Optional feature macro RESERVATION_ROB_ALLOC_BYPASS_EN:
// a CDB broadcast in the allocation cycle also wakes the new entry's sources.
module reservation_rob #(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_SIZE   = 16,
  parameter int TAG_WIDTH  = 4,
  parameter int EXEC_WIDTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  reservation_rob_if.slave bus
);

  localparam int PW = TAG_WIDTH + 1;

  // Per-entry control bits (reset) and payload (not reset).
  logic [ROB_SIZE-1:0]   valid_q, valid_d, disp_q, disp_d, done_q, done_d;
  logic [ROB_SIZE-1:0]   s1v_q, s1v_d, s2v_q, s2v_d;
  logic [TAG_WIDTH-1:0]  s1tag_q [ROB_SIZE];
  logic [TAG_WIDTH-1:0]  s1tag_d [ROB_SIZE];
  logic [TAG_WIDTH-1:0]  s2tag_q [ROB_SIZE];
  logic [TAG_WIDTH-1:0]  s2tag_d [ROB_SIZE];
  logic [DATA_WIDTH-1:0] op1_q [ROB_SIZE];
  logic [DATA_WIDTH-1:0] op1_d [ROB_SIZE];
  logic [DATA_WIDTH-1:0] op2_q [ROB_SIZE];
  logic [DATA_WIDTH-1:0] op2_d [ROB_SIZE];
  logic [EXEC_WIDTH-1:0] exec_q [ROB_SIZE];
  logic [EXEC_WIDTH-1:0] exec_d [ROB_SIZE];
  logic [DATA_WIDTH-1:0] result_q [ROB_SIZE];
  logic [DATA_WIDTH-1:0] result_d [ROB_SIZE];

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d, occupancy;
  logic [TAG_WIDTH-1:0] head_idx, tail_idx, scan_idx, sel_idx;
  logic                 full_w, alloc_fire, commit_fire, disp_found, disp_fire;
  logic                 byp1, byp2;

  assign head_idx    = head_q[TAG_WIDTH-1:0];
  assign tail_idx    = tail_q[TAG_WIDTH-1:0];
  assign occupancy   = tail_q - head_q;
  assign full_w      = (occupancy == PW'(ROB_SIZE));
  assign alloc_fire  = bus.alloc_valid & ~full_w & ~bus.halt;
  assign commit_fire = valid_q[head_idx] & done_q[head_idx] & ~bus.halt;
  assign disp_fire   = disp_found & ~bus.halt & bus.disp_ready;

`ifdef RESERVATION_ROB_ALLOC_BYPASS_EN
  assign byp1 = bus.cdb_valid & (bus.cdb_tag == bus.rs1_tag);
  assign byp2 = bus.cdb_valid & (bus.cdb_tag == bus.rs2_tag);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Oldest-first scan from head for a valid, undispatched, operand-ready entry.
  always_comb begin
    disp_found = 1'b0;
    sel_idx    = head_idx;
    scan_idx   = head_idx;
    for (int i = 0; i < ROB_SIZE; i++) begin
      scan_idx = head_idx + TAG_WIDTH'(i);
      if (!disp_found && valid_q[scan_idx] && !disp_q[scan_idx] &&
          s1v_q[scan_idx] && s2v_q[scan_idx]) begin
        disp_found = 1'b1;
        sel_idx    = scan_idx;
      end
    end
  end

  assign bus.alloc_tag    = tail_idx;
  assign bus.full         = full_w;
  assign bus.disp_valid   = disp_found & ~bus.halt;
  assign bus.disp_op1     = op1_q[sel_idx];
  assign bus.disp_op2     = op2_q[sel_idx];
  assign bus.disp_exec_id = exec_q[sel_idx];
  assign bus.disp_tag     = sel_idx;
  assign bus.commit_valid = commit_fire;
  assign bus.commit_tag   = head_idx;
  assign bus.commit_data  = result_q[head_idx];

  // Next-state: CDB wakeup/completion, dispatch marking, commit, allocation.
  always_comb begin
    valid_d  = valid_q;
    disp_d   = disp_q;
    done_d   = done_q;
    s1v_d    = s1v_q;
    s2v_d    = s2v_q;
    s1tag_d  = s1tag_q;
    s2tag_d  = s2tag_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    exec_d   = exec_q;
    result_d = result_q;
    head_d   = head_q;
    tail_d   = tail_q;

    // CDB is observed even while halted so no result is ever lost.
    if (bus.cdb_valid) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        if (valid_q[i]) begin
          if (!s1v_q[i] && (s1tag_q[i] == bus.cdb_tag)) begin
            s1v_d[i] = 1'b1;
            op1_d[i] = bus.cdb_data;
          end
          if (!s2v_q[i] && (s2tag_q[i] == bus.cdb_tag)) begin
            s2v_d[i] = 1'b1;
            op2_d[i] = bus.cdb_data;
          end
          if (TAG_WIDTH'(i) == bus.cdb_tag) begin
            done_d[i]   = 1'b1;
            result_d[i] = bus.cdb_data;
          end
        end
      end
    end

    if (disp_fire) disp_d[sel_idx] = 1'b1;

    if (commit_fire) begin
      valid_d[head_idx] = 1'b0;
      head_d            = head_q + PW'(1);
    end

    // The tail slot is never valid when not full, so this cannot clash with
    // the CDB or commit updates above.
    if (alloc_fire) begin
      valid_d[tail_idx] = 1'b1;
      disp_d[tail_idx]  = 1'b0;
      done_d[tail_idx]  = 1'b0;
      s1v_d[tail_idx]   = bus.rs1_valid | byp1;
      s2v_d[tail_idx]   = bus.rs2_valid | byp2;
      s1tag_d[tail_idx] = bus.rs1_tag;
      s2tag_d[tail_idx] = bus.rs2_tag;
      op1_d[tail_idx]   = (!bus.rs1_valid && byp1) ? bus.cdb_data : bus.rs1_data;
      op2_d[tail_idx]   = (!bus.rs2_valid && byp2) ? bus.cdb_data : bus.rs2_data;
      exec_d[tail_idx]  = bus.alloc_exec_id;
      tail_d            = tail_q + PW'(1);
    end
  end

  // Control state: cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      disp_q  <= '0;
      done_q  <= '0;
      s1v_q   <= '0;
      s2v_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      valid_q <= valid_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
      s1v_q   <= s1v_d;
      s2v_q   <= s2v_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Payload storage: only meaningful under a set control bit, so no reset.
  always_ff @(posedge clk) begin
    s1tag_q  <= s1tag_d;
    s2tag_q  <= s2tag_d;
    op1_q    <= op1_d;
    op2_q    <= op2_d;
    exec_q   <= exec_d;
    result_q <= result_d;
  end

endmodule

// File: tb/tb_reservation_rob.sv
// tb_reservation_rob: vector table for allocation/full behaviour, hand-written
// sequences for dispatch order, wakeup, commit, wrap, bypass and reset, and
// scoreboards for dispatched entries and committed results.
module tb_reservation_rob;
  localparam int DW = 32;
  localparam int RS = 4;
  localparam int TW = 2;
  localparam int EW = 4;
  localparam int DPW = TW + 2 * DW + EW;
  localparam int CPW = TW + DW;

  logic clk;
  logic rst_n;
  int   chk_cnt;
  int   pass_cnt;

  logic [DPW-1:0] exp_disp_q[$];
  logic [CPW-1:0] exp_commit_q[$];

  reservation_rob_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .EXEC_WIDTH(EW)) bus ();

  reservation_rob #(.DATA_WIDTH(DW), .ROB_SIZE(RS), .TAG_WIDTH(TW), .EXEC_WIDTH(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [DPW-1:0] dpack(input logic [TW-1:0] t, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic [EW-1:0] e);
    return {t, a, b, e};
  endfunction

  function automatic logic [CPW-1:0] cpack(input logic [TW-1:0] t, input logic [DW-1:0] d);
    return {t, d};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.halt = 1'b0; bus.alloc_valid = 1'b0; bus.alloc_exec_id = '0;
    bus.rs1_valid = 1'b0; bus.rs1_tag = '0; bus.rs1_data = '0;
    bus.rs2_valid = 1'b0; bus.rs2_tag = '0; bus.rs2_data = '0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
    bus.disp_ready = 1'b0;
  endtask

  task automatic set_alloc(input logic v1, input logic [TW-1:0] t1, input logic [DW-1:0] d1,
                           input logic v2, input logic [TW-1:0] t2, input logic [DW-1:0] d2,
                           input logic [EW-1:0] ex);
    bus.alloc_valid = 1'b1; bus.alloc_exec_id = ex;
    bus.rs1_valid = v1; bus.rs1_tag = t1; bus.rs1_data = d1;
    bus.rs2_valid = v2; bus.rs2_tag = t2; bus.rs2_data = d2;
  endtask

  task automatic set_cdb(input logic [TW-1:0] t, input logic [DW-1:0] d);
    bus.cdb_valid = 1'b1; bus.cdb_tag = t; bus.cdb_data = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Scoreboard: compare every dispatch handshake and every commit
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.disp_valid && bus.disp_ready) begin
        if (exp_disp_q.size() == 0) check("disp_unexpected", {1'b1, bus.disp_tag}, 0);
        else check("disp_entry", dpack(bus.disp_tag, bus.disp_op1, bus.disp_op2, bus.disp_exec_id),
                   exp_disp_q.pop_front());
      end
      if (bus.commit_valid) begin
        if (exp_commit_q.size() == 0) check("commit_unexpected", {1'b1, bus.commit_tag}, 0);
        else check("commit_entry", cpack(bus.commit_tag, bus.commit_data), exp_commit_q.pop_front());
      end
    end
  end

  typedef struct {
    logic          av;
    logic          halt;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [EW-1:0] ex;
    logic [TW-1:0] e_tag;
    logic          e_full;
    logic          e_dv;
    logic [TW-1:0] e_dtag;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [DW-1:0] rd;
    chk_cnt  = 0;
    pass_cnt = 0;
    vecs[0] = '{1'b1, 1'b0, 32'd1,  32'd2,  4'd1, 2'd0, 1'b0, 1'b0, 2'd0};
    vecs[1] = '{1'b1, 1'b0, 32'd3,  32'd4,  4'd2, 2'd1, 1'b0, 1'b1, 2'd0};
    vecs[2] = '{1'b1, 1'b0, 32'd5,  32'd6,  4'd3, 2'd2, 1'b0, 1'b1, 2'd0};
    vecs[3] = '{1'b1, 1'b0, 32'd7,  32'd8,  4'd4, 2'd3, 1'b0, 1'b1, 2'd0};
    vecs[4] = '{1'b1, 1'b0, 32'd9,  32'd10, 4'd5, 2'd0, 1'b1, 1'b1, 2'd0};
    vecs[5] = '{1'b1, 1'b1, 32'd11, 32'd12, 4'd6, 2'd0, 1'b1, 1'b0, 2'd0};
    vecs[6] = '{1'b0, 1'b0, 32'd13, 32'd14, 4'd7, 2'd0, 1'b1, 1'b1, 2'd0};

    // Reset state
    rst_n = 1'b0;
    drive_idle();
    tick();
    check("rst_full", bus.full, 0);
    check("rst_disp_valid", bus.disp_valid, 0);
    check("rst_commit_valid", bus.commit_valid, 0);
    check("rst_alloc_tag", bus.alloc_tag, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fill to full with disp_ready low; extra allocations ignored
    for (int i = 0; i < 7; i++) begin
      bus.alloc_valid = vecs[i].av; bus.halt = vecs[i].halt; bus.alloc_exec_id = vecs[i].ex;
      bus.rs1_valid = 1'b1; bus.rs1_data = vecs[i].d1;
      bus.rs2_valid = 1'b1; bus.rs2_data = vecs[i].d2;
      #1;
      check($sformatf("vec%0d_alloc_tag", i), bus.alloc_tag, vecs[i].e_tag);
      check($sformatf("vec%0d_full", i), bus.full, vecs[i].e_full);
      check($sformatf("vec%0d_disp_valid", i), bus.disp_valid, vecs[i].e_dv);
      if (vecs[i].e_dv) check($sformatf("vec%0d_disp_tag", i), bus.disp_tag, vecs[i].e_dtag);
      tick();
    end
    drive_idle();

    // Back-to-back dispatch in age order
    exp_disp_q.push_back(dpack(2'd0, 32'd1, 32'd2, 4'd1));
    exp_disp_q.push_back(dpack(2'd1, 32'd3, 32'd4, 4'd2));
    exp_disp_q.push_back(dpack(2'd2, 32'd5, 32'd6, 4'd3));
    exp_disp_q.push_back(dpack(2'd3, 32'd7, 32'd8, 4'd4));
    bus.disp_ready = 1'b1;
    repeat (4) tick();
    check("drained_disp_valid", bus.disp_valid, 0);
    bus.disp_ready = 1'b0;

    // Commit while full: allocation rejected, then accepted with wrapped tag
    set_cdb(2'd0, 32'h100);
    exp_commit_q.push_back(cpack(2'd0, 32'h100));
    tick();
    bus.cdb_valid = 1'b0;
    set_alloc(1'b1, 2'd0, 32'h11, 1'b1, 2'd0, 32'h22, 4'd5);
    #1;
    check("wrap_full_before", bus.full, 1);
    check("wrap_commit_valid", bus.commit_valid, 1);
    check("wrap_tag_before", bus.alloc_tag, 0);
    tick();
    check("wrap_full_after", bus.full, 0);
    check("wrap_tag_after", bus.alloc_tag, 0);
    check("wrap_no_commit", bus.commit_valid, 0);
    tick();
    bus.alloc_valid = 1'b0;
    #1;
    check("wrap_refull", bus.full, 1);
    check("wrap_disp_valid", bus.disp_valid, 1);
    check("wrap_disp_tag", bus.disp_tag, 0);
    exp_disp_q.push_back(dpack(2'd0, 32'h11, 32'h22, 4'd5));
    bus.disp_ready = 1'b1;
    tick();
    bus.disp_ready = 1'b0;

    // Out-of-order completion, in-order retirement
    exp_commit_q.push_back(cpack(2'd1, 32'h201));
    exp_commit_q.push_back(cpack(2'd2, 32'h202));
    exp_commit_q.push_back(cpack(2'd3, 32'h203));
    exp_commit_q.push_back(cpack(2'd0, 32'h200));
    set_cdb(2'd1, 32'h201); tick();
    set_cdb(2'd2, 32'h202); tick();
    set_cdb(2'd3, 32'h203); tick();
    set_cdb(2'd0, 32'h200); tick();
    bus.cdb_valid = 1'b0;
    tick();
    tick();
    check("empty_commit_valid", bus.commit_valid, 0);
    check("empty_full", bus.full, 0);
    check("empty_alloc_tag", bus.alloc_tag, 1);

    // Younger ready entry dispatches first; woken older entry follows
    do_reset();
    bus.disp_ready = 1'b1;
    set_alloc(1'b0, 2'd3, 32'd0, 1'b1, 2'd0, 32'd2, 4'd3);
    #1;
    check("wake_tag0", bus.alloc_tag, 0);
    check("wake_dv0", bus.disp_valid, 0);
    tick();
    set_alloc(1'b1, 2'd0, 32'h10, 1'b1, 2'd0, 32'h20, 4'd4);
    #1;
    check("wake_tag1", bus.alloc_tag, 1);
    check("wake_dv1", bus.disp_valid, 0);
    tick();
    bus.alloc_valid = 1'b0;
    set_cdb(2'd3, 32'h55);
    exp_disp_q.push_back(dpack(2'd1, 32'h10, 32'h20, 4'd4));
    #1;
    check("wake_first_tag", bus.disp_tag, 1);
    tick();
    bus.cdb_valid = 1'b0;
    exp_disp_q.push_back(dpack(2'd0, 32'h55, 32'd2, 4'd3));
    #1;
    check("wake_second_dv", bus.disp_valid, 1);
    check("wake_second_tag", bus.disp_tag, 0);
    check("wake_second_op1", bus.disp_op1, 32'h55);
    tick();
    bus.disp_ready = 1'b0;
    set_cdb(2'd1, 32'hAA);
    #1;
    check("wake_all_dispatched", bus.disp_valid, 0);
    tick();
    set_cdb(2'd0, 32'hBB);
    exp_commit_q.push_back(cpack(2'd0, 32'hBB));
    exp_commit_q.push_back(cpack(2'd1, 32'hAA));
    #1;
    check("order_hold_commit", bus.commit_valid, 0);
    tick();
    bus.cdb_valid = 1'b0;
    #1;
    check("order_commit0_valid", bus.commit_valid, 1);
    check("order_commit0_tag", bus.commit_tag, 0);
    tick();
    check("order_commit1_valid", bus.commit_valid, 1);
    check("order_commit1_data", bus.commit_data, 32'hAA);
    tick();
    check("order_done", bus.commit_valid, 0);

    // Same-cycle CDB match on an allocating entry's source
    set_alloc(1'b1, 2'd0, 32'd1, 1'b0, 2'd2, 32'd0, 4'd6);
    set_cdb(2'd2, 32'h7);
    #1;
    check("byp_alloc_tag", bus.alloc_tag, 2);
    tick();
    drive_idle();
    #1;
`ifdef RESERVATION_ROB_ALLOC_BYPASS_EN
    check("byp_dv", bus.disp_valid, 1);
    check("byp_tag", bus.disp_tag, 2);
    check("byp_op2", bus.disp_op2, 32'h7);
    exp_disp_q.push_back(dpack(2'd2, 32'd1, 32'h7, 4'd6));
    bus.disp_ready = 1'b1;
    tick();
    bus.disp_ready = 1'b0;
`else
    for (int i = 0; i < 3; i++) begin
      check($sformatf("nobyp_dv%0d", i), bus.disp_valid, 0);
      tick();
    end
`endif

    // Reset mid-operation with three entries and halt asserted
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rd = $urandom_range(1, 1000);
      set_alloc(1'b1, 2'd0, rd, 1'b1, 2'd0, rd + 32'd1, EW'(i));
      tick();
    end
    bus.alloc_valid = 1'b0;
    set_cdb(2'd0, 32'h33);
    tick();
    bus.cdb_valid = 1'b0;
    #1;
    check("pre_rst_commit_valid", bus.commit_valid, 1);
    check("pre_rst_disp_valid", bus.disp_valid, 1);
    check("pre_rst_alloc_tag", bus.alloc_tag, 3);
    bus.halt = 1'b1;
    #1;
    check("halt_commit_valid", bus.commit_valid, 0);
    check("halt_disp_valid", bus.disp_valid, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_full", bus.full, 0);
    check("async_rst_disp_valid", bus.disp_valid, 0);
    check("async_rst_commit_valid", bus.commit_valid, 0);
    check("async_rst_alloc_tag", bus.alloc_tag, 0);
    tick();
    rst_n = 1'b1;
    bus.halt = 1'b0;
    tick();
    set_alloc(1'b1, 2'd0, 32'h44, 1'b1, 2'd0, 32'h45, 4'd9);
    #1;
    check("post_rst_alloc_tag", bus.alloc_tag, 0);
    tick();
    bus.alloc_valid = 1'b0;
    #1;
    check("post_rst_disp_tag", bus.disp_tag, 0);
    check("post_rst_disp_op1", bus.disp_op1, 32'h44);
    check("post_rst_commit_valid", bus.commit_valid, 0);
    tick();

    // Final report
    check("disp_queue_empty", exp_disp_q.size(), 0);
    check("commit_queue_empty", exp_commit_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/reservation_rob.md
RESERVATION_ROB -- requirements
Module: reservation_rob

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter ROB_SIZE, default 16, entry count; SHALL be a power of two >= 4.
REQ-003 Parameter TAG_WIDTH, default 4, tag width; SHALL equal log2(ROB_SIZE); tag = entry index.
REQ-004 Parameter EXEC_WIDTH, default 4, execution-unit ID width.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 halt  input  1  freezes allocate, dispatch marking and commit.
REQ-008 alloc_valid  input  1  new instruction present this cycle.
REQ-009 alloc_exec_id  input  EXEC_WIDTH  target execution unit.
REQ-010 rs1_valid  input  1  1 = rs1_data valid, 0 = wait on rs1_tag.
REQ-011 rs1_tag  input  TAG_WIDTH  producer tag of operand 1.
REQ-012 rs1_data  input  DATA_WIDTH  operand 1 value.
REQ-013 rs2_valid  input  1  as rs1_valid; decoder drives immediate here with rs2_valid=1.
REQ-014 rs2_tag  input  TAG_WIDTH  producer tag of operand 2.
REQ-015 rs2_data  input  DATA_WIDTH  operand 2 value or immediate.
REQ-016 alloc_tag  output  TAG_WIDTH  tag assigned to current allocation (= tail index), to register file.
REQ-017 full  output  1  all ROB_SIZE entries occupied.
REQ-018 cdb_valid  input  1  result broadcast present.
REQ-019 cdb_tag  input  TAG_WIDTH  tag of broadcast result.
REQ-020 cdb_data  input  DATA_WIDTH  broadcast result value.
REQ-021 disp_valid  output  1  a ready, undispatched entry is offered.
REQ-022 disp_ready  input  1  execution side accepts the offer.
REQ-023 disp_op1  output  DATA_WIDTH  operand 1 of offered entry.
REQ-024 disp_op2  output  DATA_WIDTH  operand 2 of offered entry.
REQ-025 disp_exec_id  output  EXEC_WIDTH  execution ID of offered entry.
REQ-026 disp_tag  output  TAG_WIDTH  tag the unit broadcasts on completion.
REQ-027 commit_valid  output  1  head entry retires this cycle.
REQ-028 commit_tag  output  TAG_WIDTH  tag of retiring entry.
REQ-029 commit_data  output  DATA_WIDTH  result of retiring entry.

Function
REQ-030 Head/tail pointers SHALL be TAG_WIDTH+1 bits; full = (tail-head)==ROB_SIZE, empty = tail==head; wrap at ROB_SIZE by natural overflow.
REQ-031 Allocation fires when alloc_valid & ~full & ~halt: entry at tail gets valid=1, dispatched=0, done=0, sources/tags/exec_id; tail increments next edge; alloc ignored (no state change) when full, even if a commit occurs that cycle.
REQ-032 CDB (regardless of halt): every valid entry with source n not valid and tag==cdb_tag captures cdb_data and sets source valid; entry cdb_tag, if valid, sets done=1 and stores result.
REQ-033 Dispatch selection: oldest entry (searching from head toward tail) with valid, ~dispatched, both sources valid; outputs combinational from registered entry state; disp_valid=0 when none or halt.
REQ-034 An entry allocated at edge N is first eligible for dispatch in the cycle after N; a source woken by CDB at edge N is eligible after N.
REQ-035 disp_valid & disp_ready sets that entry's dispatched bit next edge; next-oldest ready entry offered following cycle; back-to-back dispatch one per cycle.
REQ-036 commit_valid = head entry valid & done & ~halt (combinational); on commit, entry valid cleared, head increments; at most one commit per cycle.
REQ-037 Simultaneous allocate and commit when not full SHALL both occur; occupancy unchanged.

Reset
REQ-038 rst_n low SHALL immediately clear head, tail, all valid/dispatched/done/source-valid bits; thus full=0, disp_valid=0, commit_valid=0, alloc_tag=0; data arrays need no reset.
REQ-039 Reset asserted mid-operation discards all entries; first allocation after release gets tag 0.

Configuration
REQ-040 Macro RESERVATION_ROB_ALLOC_BYPASS_EN defined: a CDB broadcast whose tag matches rs1_tag/rs2_tag of an allocation in the same cycle SHALL store cdb_data with source valid=1; undefined: source stored not-valid and that wakeup is lost (decoder must avoid this case).

Verification
REQ-041 ROB_SIZE=4, 4 allocs with valid sources, disp_ready=0 -> full=1 after 4th edge, 5th alloc ignored, alloc_tag stays 0.
REQ-042 Alloc tag0 (rs1 waits tag 3), tag1 ready; disp_ready=1 -> tag1 dispatched first; CDB tag3 data 0x55 -> tag0 offered next cycle with disp_op1=0x55.
REQ-043 CDB tag1 data 0xAA before tag0 done -> commit_valid=0; CDB tag0 -> commits tag0 then tag1 (0xAA) on consecutive cycles.
REQ-044 Fill to 4, commit head while alloc_valid=1 -> alloc rejected that cycle, accepted next cycle with alloc_tag wrapped to 0.
REQ-045 With bypass macro: alloc rs2_tag=2 while CDB tag2 data 0x7 -> entry immediately dispatchable, disp_op2=0x7; without macro entry never dispatches.
REQ-046 Assert rst_n low with 3 entries and halt=1 -> full=0, disp_valid=0, commit_valid=0 at once; next alloc_tag=0.
